// File: rtl/int_to_float_seq_if.sv
// Handshake bundle for int_to_float_seq.
// Valid/ready: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds valid and data stable until that edge;
// ready never depends on valid in the same cycle.
interface int_to_float_seq_if #(
  parameter int INT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [INT_WIDTH-1:0] intin;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          floatout;

  // Integer source / float consumer side.
  modport master (
    output in_valid, intin, out_ready,
    input  in_ready, out_valid, floatout
  );

  // Converter side.
  modport slave (
    input  in_valid, intin, out_ready,
    output in_ready, out_valid, floatout
  );
endinterface

// File: rtl/int_to_float_seq.sv
// Sequential integer to IEEE-754 single-precision converter.
// One conversion at a time: accept, normalise one bit per cycle, pack, hold.
// Optional feature macro: INTTOFLOAT_RNE_EN enables round-to-nearest-even for
// INT_WIDTH > 24; without it the extra low bits are truncated.
module int_to_float_seq #(
  parameter int INT_WIDTH = 16,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  int_to_float_seq_if.slave    bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Biased exponent of a value whose leading one sits in bit INT_WIDTH-1.
  localparam logic [7:0] EXP_INIT = 8'(127 + INT_WIDTH - 1);

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic [INT_WIDTH-1:0] mag_q, mag_d;
  logic [7:0]           exp_q, exp_d;
  logic [31:0]          floatout_q, floatout_d;

  logic [22:0]          frac_pack;
  logic [7:0]           exp_pack;

  // Fraction extraction: bits below the leading one, left-aligned to 23 bits.
  generate
    if (INT_WIDTH <= 24) begin : g_narrow
      assign frac_pack = 23'(mag_q[INT_WIDTH-2:0]) << (24 - INT_WIDTH);
      assign exp_pack  = exp_q;
    end else begin : g_wide
      logic [22:0] frac_t;
      assign frac_t = mag_q[INT_WIDTH-2 -: 23];
`ifdef INTTOFLOAT_RNE_EN
      logic        guard_b, sticky_b, lsb_b, round_up;
      logic [23:0] frac_sum;
      assign guard_b = mag_q[INT_WIDTH-25];
      assign lsb_b   = mag_q[INT_WIDTH-24];
      if (INT_WIDTH == 25) begin : g_no_sticky
        assign sticky_b = 1'b0;
      end else begin : g_sticky
        assign sticky_b = |mag_q[INT_WIDTH-26:0];
      end
      assign round_up  = guard_b & (sticky_b | lsb_b);
      // A carry out of the fraction leaves it all-zero and bumps the exponent.
      assign frac_sum  = {1'b0, frac_t} + {23'd0, round_up};
      assign frac_pack = frac_sum[22:0];
      assign exp_pack  = exp_q + {7'd0, frac_sum[23]};
`else
      logic unused_low_bits;
      assign unused_low_bits = ^mag_q[INT_WIDTH-25:0];
      assign frac_pack = frac_t;
      assign exp_pack  = exp_q;
`endif
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      mag_q      <= '0;
      exp_q      <= 8'd0;
      floatout_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      floatout_q <= floatout_d;
    end
  end

  // Next-state and datapath update for accept / normalise / pack / hold.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    floatout_d = floatout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = SIGNED_IN & bus.intin[INT_WIDTH-1];
          // Two's-complement negate; the most negative value wraps to 2^(W-1).
          mag_d   = sign_d ? (~bus.intin + 1'b1) : bus.intin;
          exp_d   = EXP_INIT;
          zero_d  = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else if (mag_q[INT_WIDTH-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      PACK: begin
        floatout_d = zero_q ? 32'h0 : {sign_q, exp_pack, frac_pack};
        state_d    = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.floatout  = floatout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Bench for int_to_float_seq: three instances (W=16 signed, W=16 unsigned,
// W=32 signed). Latency is counted with the accept cycle as cycle 1.
module tb_int_to_float_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int          sel;
  logic        drv_valid;
  logic [31:0] drv_data;
  logic        drv_oready;

  int_to_float_seq_if #(.INT_WIDTH(16)) if_a ();
  int_to_float_seq_if #(.INT_WIDTH(16)) if_b ();
  int_to_float_seq_if #(.INT_WIDTH(32)) if_c ();

  logic [1:0] st_a, st_b, st_c;

  assign if_a.in_valid  = drv_valid && (sel == 0);
  assign if_a.intin     = drv_data[15:0];
  assign if_a.out_ready = drv_oready && (sel == 0);
  assign if_b.in_valid  = drv_valid && (sel == 1);
  assign if_b.intin     = drv_data[15:0];
  assign if_b.out_ready = drv_oready && (sel == 1);
  assign if_c.in_valid  = drv_valid && (sel == 2);
  assign if_c.intin     = drv_data;
  assign if_c.out_ready = drv_oready && (sel == 2);

  int_to_float_seq #(.INT_WIDTH(16), .SIGNED_IN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .state_o(st_a));
  int_to_float_seq #(.INT_WIDTH(16), .SIGNED_IN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .state_o(st_b));
  int_to_float_seq #(.INT_WIDTH(32), .SIGNED_IN(1'b1)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c), .state_o(st_c));

  logic        obs_valid, obs_ready;
  logic [31:0] obs_float;
  logic [1:0]  obs_state;

  always_comb begin
    obs_valid = if_a.out_valid;
    obs_ready = if_a.in_ready;
    obs_float = if_a.floatout;
    obs_state = st_a;
    case (sel)
      1: begin
        obs_valid = if_b.out_valid; obs_ready = if_b.in_ready;
        obs_float = if_b.floatout;  obs_state = st_b;
      end
      2: begin
        obs_valid = if_c.out_valid; obs_ready = if_c.in_ready;
        obs_float = if_c.floatout;  obs_state = st_c;
      end
      default: ;
    endcase
  end

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference value for a 16-bit input, found by searching for the top set bit.
  function automatic logic [31:0] model16(input logic [15:0] v, input bit sgn);
    int          m;
    int          p;
    bit          s;
    logic [31:0] frac;
    s = sgn && v[15];
    m = s ? (65536 - int'(v)) : int'(v);
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 17; i++) if (((m >> i) & 1) == 1) p = i;
    frac = 32'((m - (1 << p)) << (23 - p));
    return {s, 8'(127 + p), frac[22:0]};
  endfunction

  function automatic int lat16(input logic [15:0] v, input bit sgn);
    int m;
    int p;
    m = (sgn && v[15]) ? (65536 - int'(v)) : int'(v);
    if (m == 0) return 3;
    p = 0;
    for (int i = 0; i < 17; i++) if (((m >> i) & 1) == 1) p = i;
    return (15 - p) + 3;
  endfunction

  // One full conversion: drive, push expectations, wait for out_valid,
  // compare, then stall in HOLD for 'stall' cycles (or leave with out_ready
  // already high when pre_ready is set).
  task automatic convert(input int s, input logic [31:0] data, input logic [31:0] expf,
                         input int explat, input bit pre_ready, input int stall);
    int          cnt;
    logic [31:0] held;
    sel        = s;
    drv_oready = pre_ready;
    @(negedge clk);
    check_eq("in_ready_idle", {31'd0, obs_ready}, 32'd1);
    drv_valid = 1'b1;
    drv_data  = data;
    exp_q.push_back(expf);
    lat_q.push_back(explat);
    @(negedge clk);
    drv_valid = 1'b0;
    cnt = 1;
    while (!obs_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!obs_valid) begin
      check_eq("out_valid_timeout", {31'd0, obs_valid}, 32'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
    end else begin
      check_eq("latency", 32'(cnt), 32'(lat_q.pop_front()));
      check_eq("floatout", obs_float, exp_q.pop_front());
      held = obs_float;
      if (pre_ready) begin
        @(negedge clk);
        check_eq("one_cycle_hold_ready", {31'd0, obs_ready}, 32'd1);
        check_eq("one_cycle_hold_valid", {31'd0, obs_valid}, 32'd0);
      end else begin
        for (int i = 0; i < stall; i++) begin
          drv_valid = (i % 2 == 0);
          drv_data  = ~data;
          @(negedge clk);
          check_eq("stall_in_ready", {31'd0, obs_ready}, 32'd0);
          check_eq("stall_out_valid", {31'd0, obs_valid}, 32'd1);
          check_eq("stall_floatout", obs_float, held);
        end
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", {31'd0, obs_ready}, 32'd1);
        check_eq("release_out_valid", {31'd0, obs_valid}, 32'd0);
      end
    end
    drv_oready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv;
    reset      = 1'b1;
    sel        = 0;
    drv_valid  = 1'b0;
    drv_data   = 32'h0;
    drv_oready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst_in_ready", {31'd0, obs_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, obs_valid}, 32'd0);
      check_eq("rst_floatout", obs_float, 32'h0);
      check_eq("rst_state", {30'd0, obs_state}, 32'd0);
    end

    // W=16 signed directed sequence; 7fff carries the 10-cycle backpressure.
    convert(0, 32'h7fff, 32'h46fffe00, 4, 1'b0, 10);
    convert(0, 32'h8000, 32'hc7000000, 3, 1'b1, 0);
    convert(0, 32'h0000, 32'h00000000, 3, 1'b0, 1);
    convert(0, 32'h000f, 32'h41700000, 15, 1'b0, 0);
    convert(0, 32'hffe5, 32'hc1d80000, 14, 1'b0, 2);

    // W=16 unsigned.
    convert(1, 32'hffff, 32'h477fff00, 3, 1'b0, 1);
    convert(1, 32'h8000, 32'h47000000, 3, 1'b0, 0);

    // W=32 signed, rounding depends on build.
`ifdef INTTOFLOAT_RNE_EN
    convert(2, 32'h01000003, 32'h4b800002, 10, 1'b0, 0);
    convert(2, 32'h7fffffff, 32'h4f000000, 4, 1'b0, 1);
`else
    convert(2, 32'h01000003, 32'h4b800001, 10, 1'b0, 0);
    convert(2, 32'h7fffffff, 32'h4effffff, 4, 1'b0, 1);
`endif
    convert(2, 32'h80000000, 32'hcf000000, 3, 1'b0, 0);

    // Random W=16 values on both signed and unsigned instances.
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom_range(0, 65535));
      convert(0, {16'd0, rv}, model16(rv, 1'b1), lat16(rv, 1'b1), 1'b0, int'($urandom_range(0, 3)));
      rv = 16'($urandom_range(0, 65535));
      convert(1, {16'd0, rv}, model16(rv, 1'b0), lat16(rv, 1'b0), 1'b0, int'($urandom_range(0, 3)));
    end

    // Reset during NORM aborts the conversion of 0x0001.
    sel = 0;
    @(negedge clk);
    drv_valid = 1'b1;
    drv_data  = 32'h0001;
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_out_valid", {31'd0, obs_valid}, 32'd0);
    check_eq("abort_in_ready", {31'd0, obs_ready}, 32'd1);
    check_eq("abort_floatout", obs_float, 32'h0);
    convert(0, 32'h000f, 32'h41700000, 15, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
